sdram_port_responder: RTL and testbench

//   Responder end of the toggle-handshake port protocol used by the ROM download

---
 rtl/sdram_port_responder.sv | 185 ++++++++++++++++++
 tb/tb_sdram_port_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_responder.sv
// Responder side of the toggle-handshake memory port: captures one pending access,
// requests a memory slot, performs a masked write or a read, then toggles port_ack.
module sdram_port_responder #(
  parameter int AW      = 23,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            port_req,
  output logic            port_ack,
  input  logic [AW-1:0]   port_a,
  input  logic [DW/8-1:0] port_ds,
  input  logic            port_we,
  input  logic [DW-1:0]   port_d,
  output logic [DW-1:0]   port_q,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_ds,
  output logic            mem_we,
  output logic [DW-1:0]   mem_d,
  input  logic [DW-1:0]   mem_q,
  input  logic            mem_qv,
  output logic            busy,
  output logic            err_timeout,
  input  logic            err_clr
);

  localparam int BW = DW / 8;
  localparam int TW = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 32'sd1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 32'sd0) ? TIMEOUT - 32'sd1 : 32'sd0);
  localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};
  localparam logic          TO_EN  = (TIMEOUT > 32'sd0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic            tag_r, tag_s;
  logic [TW-1:0]   timer_r, timer_s;
  logic            ack_r, ack_s;
  logic [DW-1:0]   q_r, q_s;
  logic            req_r, req_s;
  logic [AW-1:0]   addr_r, addr_s;
  logic [BW-1:0]   ds_r, ds_s;
  logic            we_r, we_s;
  logic [DW-1:0]   d_r, d_s;
  logic            err_r, err_s;
  logic            err_set_s;
  logic            busy_r, busy_s;
  logic            timeout_hit_s;

  assign timeout_hit_s = TO_EN && (timer_r == T_LAST);

  // Next-state, timer and output-register decode.
  always_comb begin
    state_s   = state_r;
    tag_s     = tag_r;
    timer_s   = (timer_r == T_MAX) ? timer_r : timer_r + TW'(1'b1);
    ack_s     = ack_r;
    q_s       = q_r;
    req_s     = req_r;
    addr_s    = addr_r;
    ds_s      = ds_r;
    we_s      = we_r;
    d_s       = d_r;
    err_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_s = '0;
        if (port_req != ack_r) begin
          addr_s = port_a;
          ds_s   = port_ds;
          we_s   = port_we;
          d_s    = port_d;
          tag_s  = port_req;
          if (port_we && (port_ds == {BW{1'b0}})) begin
            ack_s   = port_req;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_ISSUE;
            req_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_gnt) begin
          req_s   = 1'b0;
          timer_s = '0;
          if (we_r) begin
            ack_s   = tag_r;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT_RD;
          end
        end else if (timeout_hit_s) begin
          req_s     = 1'b0;
          timer_s   = '0;
          err_set_s = 1'b1;
          ack_s     = tag_r;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT_RD: begin
        if (mem_qv) begin
          q_s     = mem_q;
          ack_s   = tag_r;
          timer_s = '0;
          state_s = ST_IDLE;
        end else if (timeout_hit_s) begin
          err_set_s = 1'b1;
          ack_s     = tag_r;
          timer_s   = '0;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_WAIT_RD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        req_s   = 1'b0;
        timer_s = '0;
      end
    endcase
    // set wins over a simultaneous clear
    if (err_set_s) begin
      err_s = 1'b1;
    end else if (err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      tag_r   <= 1'b0;
      timer_r <= '0;
      ack_r   <= 1'b0;
      q_r     <= '0;
      req_r   <= 1'b0;
      addr_r  <= '0;
      ds_r    <= '0;
      we_r    <= 1'b0;
      d_r     <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      tag_r   <= tag_s;
      timer_r <= timer_s;
      ack_r   <= ack_s;
      q_r     <= q_s;
      req_r   <= req_s;
      addr_r  <= addr_s;
      ds_r    <= ds_s;
      we_r    <= we_s;
      d_r     <= d_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
    end
  end

  assign port_ack    = ack_r;
  assign port_q      = q_r;
  assign mem_req     = req_r;
  assign mem_addr    = addr_r;
  assign mem_ds      = ds_r;
  assign mem_we      = we_r;
  assign mem_d       = d_r;
  assign busy        = busy_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_sdram_port_responder.sv
// Directed bench for sdram_port_responder: write, read, null write, re-toggle,
// timeout and mid-access reset, with hand-computed expectations.
module tb_sdram_port_responder;

  localparam int AW = 23;
  localparam int DW = 16;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic            port_req = 1'b0;
  logic            port_ack;
  logic [AW-1:0]   port_a = '0;
  logic [DW/8-1:0] port_ds = '0;
  logic            port_we = 1'b0;
  logic [DW-1:0]   port_d = '0;
  logic [DW-1:0]   port_q;
  logic            mem_req;
  logic            mem_gnt = 1'b0;
  logic [AW-1:0]   mem_addr;
  logic [DW/8-1:0] mem_ds;
  logic            mem_we;
  logic [DW-1:0]   mem_d;
  logic [DW-1:0]   mem_q = '0;
  logic            mem_qv = 1'b0;
  logic            busy;
  logic            err_timeout;
  logic            err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int gnt_cnt = 0;
  int gnt_base = 0;

  sdram_port_responder #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_ds(port_ds),
    .port_we(port_we), .port_d(port_d), .port_q(port_q),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_ds(mem_ds),
    .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q), .mem_qv(mem_qv),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk_sys = ~clk_sys;

  // Count accesses actually consumed by a grant.
  always @(posedge clk_sys) begin
    if (mem_req && mem_gnt) gnt_cnt++;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_ack", 32'(port_ack), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_q", 32'(port_q), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    reset_n = 1'b1;
    step();

    // 1: write, grant on first ISSUE cycle
    port_a = 23'h00010; port_ds = 2'b01; port_we = 1'b1; port_d = 16'hA55A; port_req = 1'b1;
    step();
    chk("w_mem_req", 32'(mem_req), 32'd1);
    chk("w_busy", 32'(busy), 32'd1);
    chk("w_addr", 32'(mem_addr), 32'h10);
    chk("w_ds", 32'(mem_ds), 32'h1);
    chk("w_d", 32'(mem_d), 32'hA55A);
    chk("w_we", 32'(mem_we), 32'd1);
    chk("w_ack_early", 32'(port_ack), 32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("w_ack", 32'(port_ack), 32'd1);
    chk("w_req_drop", 32'(mem_req), 32'd0);
    chk("w_idle", 32'(busy), 32'd0);

    // 2: read, grant after 5 ISSUE cycles, stray qv ignored
    port_a = 23'h1FFFF; port_ds = 2'b11; port_we = 1'b0; port_req = 1'b0;
    step();
    chk("r_mem_req", 32'(mem_req), 32'd1);
    chk("r_we", 32'(mem_we), 32'd0);
    chk("r_addr", 32'(mem_addr), 32'h1FFFF);
    mem_qv = 1'b1; mem_q = 16'hDEAD;
    step();
    mem_qv = 1'b0;
    step();
    step();
    step();
    chk("r_stray_q", 32'(port_q), 32'd0);
    chk("r_ack_wait", 32'(port_ack), 32'd1);
    chk("r_still_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("r_wait_req", 32'(mem_req), 32'd0);
    chk("r_wait_busy", 32'(busy), 32'd1);
    step();
    step();
    mem_qv = 1'b1; mem_q = 16'h1234;
    step();
    mem_qv = 1'b0;
    chk("r_q", 32'(port_q), 32'h1234);
    chk("r_ack", 32'(port_ack), 32'd0);
    chk("r_idle", 32'(busy), 32'd0);

    // 3: null write
    gnt_base = gnt_cnt;
    port_we = 1'b1; port_ds = 2'b00; port_req = 1'b1;
    step();
    chk("n_ack", 32'(port_ack), 32'd1);
    chk("n_req", 32'(mem_req), 32'd0);
    chk("n_busy", 32'(busy), 32'd0);
    step();
    chk("n_req2", 32'(mem_req), 32'd0);
    chk("n_busy2", 32'(busy), 32'd0);

    // 4: re-toggle during a held ISSUE
    port_a = 23'h00100; port_ds = 2'b11; port_d = 16'h1111; port_req = 1'b0;
    step();
    step();
    step();
    port_req = 1'b1; port_a = 23'h00200; port_d = 16'h2222;
    step();
    chk("rt_addr_hold", 32'(mem_addr), 32'h100);
    chk("rt_d_hold", 32'(mem_d), 32'h1111);
    chk("rt_ack_hold", 32'(port_ack), 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rt_ack1", 32'(port_ack), 32'd0);
    chk("rt_req_gap", 32'(mem_req), 32'd0);
    step();
    chk("rt_req2", 32'(mem_req), 32'd1);
    chk("rt_addr2", 32'(mem_addr), 32'h200);
    chk("rt_d2", 32'(mem_d), 32'h2222);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rt_ack2", 32'(port_ack), 32'd1);
    chk("rt_gnt_cnt", 32'(gnt_cnt - gnt_base), 32'd2);

    // 5: timeout with TIMEOUT=8
    port_a = 23'h00005; port_ds = 2'b10; port_we = 1'b1; port_req = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_req_%0d", i), 32'(mem_req), 32'd1);
      step();
    end
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_ack", 32'(port_ack), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_q_hold", 32'(port_q), 32'h1234);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(err_timeout), 32'd0);

    // 6: async reset while in WAIT_RD
    port_we = 1'b1; port_ds = 2'b00; port_req = 1'b1;
    step();
    chk("rs_null_ack", 32'(port_ack), 32'd1);
    port_a = 23'h00042; port_ds = 2'b11; port_we = 1'b0; port_req = 1'b0;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rs_in_wait", 32'(busy), 32'd1);
    chk("rs_ack_pre", 32'(port_ack), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_req", 32'(mem_req), 32'd0);
    chk("rs_ack", 32'(port_ack), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_addr", 32'(mem_addr), 32'd0);
    port_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    port_a = 23'h00077; port_ds = 2'b11; port_we = 1'b1; port_d = 16'hBEEF; port_req = 1'b1;
    step();
    chk("rs_w_req", 32'(mem_req), 32'd1);
    chk("rs_w_addr", 32'(mem_addr), 32'h77);
    chk("rs_w_d", 32'(mem_d), 32'hBEEF);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("rs_w_ack", 32'(port_ack), 32'd1);
    chk("rs_w_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
